sprite_motion_engine: RTL
=========================

Name: sprite_motion_engine

Overview:
Parametrised successor to the fixed sprite-position generator: holds position and velocity state for SPRITES sprites and advances them once per video frame with wall bounce and optional gravity. Sits between the 162 MHz clock domain and VGA_driver, and drives its packed sprite_row/sprite_col buses directly. A valid/ready load port lets a future controller place and launch individual sprites.

Parameters:
SPRITES, 4, number of sprites tracked.
H_RES, 1600, visible columns.
V_RES, 1200, visible rows.
SPRITE_DIM, 127, sprite bounding-box edge in pixels.
VEL_W, 8, velocity width, signed two's complement.
VEL_INIT, 2, reset velocity on both axes for every sprite.
GRAVITY, 1, row-velocity increment per frame when gravity_en=1.

Ports:
clock_162  in  1  pixel clock, 162 MHz
rst_n  in  1  reset, asynchronous, active-low
frame_tick  in  1  one-cycle pulse at start of vertical blank
enable  in  1  0 = freeze motion; frame_tick still acknowledged
gravity_en  in  1  apply GRAVITY to row velocity
load_valid  in  1  load request
load_ready  out  1  load accepted when valid & ready
load_idx  in  $clog2(SPRITES)  sprite to load
load_row  in  11  new row
load_col  in  12  new column
load_vrow  in  VEL_W  new row velocity
load_vcol  in  VEL_W  new column velocity
sprite_row  out  [SPRITES-1:0][10:0]  top-left row per sprite
sprite_col  out  [SPRITES-1:0][11:0]  top-left column per sprite
busy  out  1  update sweep in progress
update_done  out  1  one-cycle pulse at end of sweep
overrun  out  1  sticky: frame_tick arrived while busy; cleared only by reset

Behaviour:
- Limits: ROW_MAX = V_RES-SPRITE_DIM (1073); COL_MAX = H_RES-SPRITE_DIM (1473).
- Reset values: sprite_row[i]=0; sprite_col[i]=min(i*128, COL_MAX); vrow=vcol=VEL_INIT; busy=0; update_done=0; overrun=0; load_ready=1; FSM=IDLE.
- FSM states are IDLE, SWEEP and DONE.
  - IDLE: load_ready=1. frame_tick causes idx<=0 and a move to SWEEP next cycle.
  - SWEEP: busy=1, load_ready=0. One sprite is updated per cycle (sprite idx); idx increments. After idx=SPRITES-1 the FSM moves to DONE.
  - DONE: update_done=1 for exactly one cycle, then IDLE.
- Latency: frame_tick in cycle t updates sprite i at the clock edge ending cycle t+1+i. update_done is high in cycle t+SPRITES+1. load_ready returns to 1 in cycle t+SPRITES+2.
- Per-sprite update, when enable=1; extend pos and vel to 14-bit signed before adding:
  - n = pos + vel.
  - If n<0: pos=0 and vel=-vel.
  - Else if n>MAX: pos=MAX and vel=-vel.
  - Else: pos=n.
  - Negation of the most-negative velocity saturates to +(2^(VEL_W-1)-1).
  - Gravity is applied after the row bounce when gravity_en=1: vrow=sat(vrow+GRAVITY) to the VEL_W signed range.
- When enable=0 the sweep still runs and update_done still pulses, but no state changes.
- Load: accepted only in IDLE.
  - Position is clamped to MAX per axis; velocity is taken verbatim.
  - Written at the edge of the accepting cycle.
  - load_idx >= SPRITES: the handshake completes but no state is written.
- Same-cycle load and frame_tick in IDLE: the load is written first, and the sweep uses the loaded values.
- frame_tick while in SWEEP or DONE is ignored and sets overrun.
- Outputs are registers only; no combinational path runs from inputs to sprite_row/sprite_col.
- Asynchronous reset asserted mid-sweep returns all state to its reset values immediately. Sprites already swept in that frame are not preserved.

Decomposition:
- Package sprite_pkg holds:
  - constants ROW_W=11, COL_W=12, H_RES/V_RES defaults, SPRITE_DIM;
  - typedef pos_row_t and pos_col_t;
  - typedef vel_t (signed VEL_W);
  - typedef struct sprite_state_t {row, col, vrow, vcol};
  - enum motion_state_t {IDLE, SWEEP, DONE}.
- Sub-module axis_bounce is natural: combinational pos/vel/max in, next pos/vel out. Two instances are shared across the sweep, one for rows and one for columns.

Test Plan:
1. Reset release, no ticks: sprite_col = {0,128,256,384} for i=0..3, sprite_row all 0, load_ready=1, overrun=0.
2. Single frame_tick, enable=1, gravity_en=0: 5 cycles later update_done=1; sprite0 is at row 2, col 2 and sprite3 at row 2, col 386.
3. Load sprite1 with row=1072, col=1472, vrow=+5, vcol=+5, then frame_tick: row=1073, col=1473, vrow=-5, vcol=-5. A second tick gives row=1068, col=1468.
4. gravity_en=1, sprite0 loaded row=0, vrow=-3, then 3 ticks: after tick 1 row=0, vrow=+4; after tick 2 row=4, vrow=+5; after tick 3 row=9, vrow=+6.
5. Further loading and tick cases:
   - load_valid and frame_tick in the same cycle, load row=500, vrow=0, gravity off: after the sweep row=500.
   - frame_tick one cycle after the first tick: overrun=1 and stays 1.
   - load_valid during SWEEP: load_ready=0 and no write occurs.
6. rst_n pulled low at sweep cycle 2 with enable=1: all outputs return to reset values asynchronously. Then enable=0 plus a tick: update_done pulses and positions are unchanged.

Source files
------------

// File: rtl/sprite_motion_engine_pkg.sv
// Shared types and constants for the sprite motion engine: coordinate widths,
// per-sprite state layout, sweep FSM states and reset placement helper.
package sprite_pkg;

  localparam int ROW_W          = 11;
  localparam int COL_W          = 12;
  localparam int H_RES_DEF      = 1600;
  localparam int V_RES_DEF      = 1200;
  localparam int SPRITE_DIM_DEF = 127;
  localparam int VEL_W_DEF      = 8;
  localparam int EXT_W          = 14;

  typedef logic [ROW_W-1:0]            pos_row_t;
  typedef logic [COL_W-1:0]            pos_col_t;
  typedef logic signed [VEL_W_DEF-1:0] vel_t;

  typedef struct packed {
    pos_row_t row;
    pos_col_t col;
    vel_t     vrow;
    vel_t     vcol;
  } sprite_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } motion_state_t;

  // Sprites start side by side on a 128-pixel pitch, held inside the screen.
  function automatic pos_col_t init_col(input int idx, input int col_max);
    int c;
    c = idx * 128;
    if (c > col_max) begin
      c = col_max;
    end else begin
      c = c;
    end
    return COL_W'(c);
  endfunction

endpackage

// File: rtl/sprite_motion_engine_axis_bounce.sv
// One axis of sprite motion: advance position by velocity, reflect off the
// walls at 0 and MAX, then optionally add gravity with saturation.
module axis_bounce
  import sprite_pkg::*;
#(
  parameter int POS_W   = 11,
  parameter int VEL_W   = 8,
  parameter int MAX     = 1073,
  parameter int GRAVITY = 1
) (
  input  logic                    [POS_W-1:0] pos,
  input  logic signed             [VEL_W-1:0] vel,
  input  logic                                grav_en,
  output logic                    [POS_W-1:0] pos_next,
  output logic signed             [VEL_W-1:0] vel_next
);

  localparam logic signed [EXT_W-1:0] ZERO_S = EXT_W'(0);
  localparam logic signed [EXT_W-1:0] MAX_S  = EXT_W'(MAX);
  localparam logic signed [EXT_W-1:0] VMAX_S = EXT_W'((1 << (VEL_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] VMIN_S = EXT_W'(-(1 << (VEL_W - 1)));
  localparam logic signed [EXT_W-1:0] GRAV_S = EXT_W'(GRAVITY);

  logic signed [EXT_W-1:0] vel_ext_s;
  logic signed [EXT_W-1:0] sum_s;
  logic signed [EXT_W-1:0] neg_s;
  logic signed [EXT_W-1:0] pos_ext_s;
  logic signed [EXT_W-1:0] bvel_s;
  logic signed [EXT_W-1:0] grav_s;
  logic signed [EXT_W-1:0] vsat_s;

  // Bounce and gravity evaluation for the sprite currently being swept.
  always_comb begin
    vel_ext_s = EXT_W'(vel);
    sum_s     = $signed({{(EXT_W-POS_W){1'b0}}, pos}) + vel_ext_s;
    // Reflecting the most-negative velocity has no positive twin; clip it.
    neg_s     = (vel_ext_s == VMIN_S) ? VMAX_S : -vel_ext_s;
    if (sum_s < ZERO_S) begin
      pos_ext_s = ZERO_S;
      bvel_s    = neg_s;
    end else if (sum_s > MAX_S) begin
      pos_ext_s = MAX_S;
      bvel_s    = neg_s;
    end else begin
      pos_ext_s = sum_s;
      bvel_s    = vel_ext_s;
    end
    if (grav_en) begin
      grav_s = bvel_s + GRAV_S;
    end else begin
      grav_s = bvel_s;
    end
    if (grav_s > VMAX_S) begin
      vsat_s = VMAX_S;
    end else if (grav_s < VMIN_S) begin
      vsat_s = VMIN_S;
    end else begin
      vsat_s = grav_s;
    end
    pos_next = POS_W'(pos_ext_s);
    vel_next = VEL_W'(vsat_s);
  end

endmodule

// File: rtl/sprite_motion_engine.sv
// Per-frame sprite position/velocity engine: one sprite is advanced per clock
// during a sweep triggered by frame_tick; sprites can be placed while idle.
module sprite_motion_engine
  import sprite_pkg::*;
#(
  parameter int SPRITES    = 4,
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int SPRITE_DIM = SPRITE_DIM_DEF,
  parameter int VEL_W      = VEL_W_DEF,
  parameter int VEL_INIT   = 2,
  parameter int GRAVITY    = 1
) (
  input  logic                             clock_162,
  input  logic                             rst_n,
  input  logic                             frame_tick,
  input  logic                             enable,
  input  logic                             gravity_en,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [$clog2(SPRITES)-1:0]       load_idx,
  input  logic [10:0]                      load_row,
  input  logic [11:0]                      load_col,
  input  logic [VEL_W-1:0]                 load_vrow,
  input  logic [VEL_W-1:0]                 load_vcol,
  output logic [SPRITES-1:0][10:0]         sprite_row,
  output logic [SPRITES-1:0][11:0]         sprite_col,
  output logic                             busy,
  output logic                             update_done,
  output logic                             overrun
);

  localparam int IDX_W   = $clog2(SPRITES);
  localparam int ROW_MAX = V_RES - SPRITE_DIM;
  localparam int COL_MAX = H_RES - SPRITE_DIM;
  localparam logic [ROW_W-1:0] ROW_MAX_V = ROW_W'(ROW_MAX);
  localparam logic [COL_W-1:0] COL_MAX_V = COL_W'(COL_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SPRITES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W:0]   IDX_LIMIT = (IDX_W + 1)'(SPRITES);

  motion_state_t           state_r, state_n;
  logic [IDX_W-1:0]        idx_r, idx_n;
  logic signed [VEL_W-1:0] vrow_r [SPRITES];
  logic signed [VEL_W-1:0] vcol_r [SPRITES];

  logic                    load_wr_s;
  logic                    sweep_wr_s;
  logic [ROW_W-1:0]        row_ld_s;
  logic [COL_W-1:0]        col_ld_s;
  logic [ROW_W-1:0]        row_next_s;
  logic [COL_W-1:0]        col_next_s;
  logic signed [VEL_W-1:0] vrow_next_s;
  logic signed [VEL_W-1:0] vcol_next_s;

  // Out-of-range indices still complete the handshake but write nothing.
  assign load_wr_s  = load_valid && (state_r == IDLE) && ({1'b0, load_idx} < IDX_LIMIT);
  assign sweep_wr_s = (state_r == SWEEP) && enable;
  assign row_ld_s   = (load_row > ROW_MAX_V) ? ROW_MAX_V : load_row;
  assign col_ld_s   = (load_col > COL_MAX_V) ? COL_MAX_V : load_col;

  axis_bounce #(
    .POS_W(ROW_W), .VEL_W(VEL_W), .MAX(ROW_MAX), .GRAVITY(GRAVITY)
  ) u_row_axis (
    .pos(sprite_row[idx_r]), .vel(vrow_r[idx_r]), .grav_en(gravity_en),
    .pos_next(row_next_s), .vel_next(vrow_next_s)
  );

  axis_bounce #(
    .POS_W(COL_W), .VEL_W(VEL_W), .MAX(COL_MAX), .GRAVITY(GRAVITY)
  ) u_col_axis (
    .pos(sprite_col[idx_r]), .vel(vcol_r[idx_r]), .grav_en(1'b0),
    .pos_next(col_next_s), .vel_next(vcol_next_s)
  );

  // Sweep sequencing: next state and sprite index.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    case (state_r)
      IDLE: begin
        if (frame_tick) begin
          state_n = SWEEP;
          idx_n   = {IDX_W{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      SWEEP: begin
        if (idx_r == IDX_LAST) begin
          state_n = DONE;
        end else begin
          idx_n = idx_r + IDX_ONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        idx_n   = {IDX_W{1'b0}};
      end
    endcase
  end

  // FSM registers plus status outputs registered from the next state.
  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      busy        <= 1'b0;
      update_done <= 1'b0;
      load_ready  <= 1'b1;
      overrun     <= 1'b0;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      busy        <= (state_n == SWEEP);
      update_done <= (state_n == DONE);
      load_ready  <= (state_n == IDLE);
      if (frame_tick && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

  // Sprite state: loads only happen in IDLE and sweep writes only in SWEEP.
  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SPRITES; i++) begin
        sprite_row[i] <= {ROW_W{1'b0}};
        sprite_col[i] <= init_col(i, COL_MAX);
        vrow_r[i]     <= VEL_W'(VEL_INIT);
        vcol_r[i]     <= VEL_W'(VEL_INIT);
      end
    end else if (load_wr_s) begin
      sprite_row[load_idx] <= row_ld_s;
      sprite_col[load_idx] <= col_ld_s;
      vrow_r[load_idx]     <= $signed(load_vrow);
      vcol_r[load_idx]     <= $signed(load_vcol);
    end else if (sweep_wr_s) begin
      sprite_row[idx_r] <= row_next_s;
      sprite_col[idx_r] <= col_next_s;
      vrow_r[idx_r]     <= vrow_next_s;
      vcol_r[idx_r]     <= vcol_next_s;
    end else begin
      sprite_row <= sprite_row;
    end
  end

endmodule
